// File: rtl/interrupt_ctrl_pkg.sv
// Shared CP0 encodings for the interrupt sequencer: coprocessor ops, register numbers,
// Status/Cause field positions and the sequencer state type.
package interrupt_ctrl_pkg;

  typedef logic [1:0] cp_oper_t;
  typedef logic [2:0] irq_idx_t;

  localparam cp_oper_t EXE_CP_NONE  = 2'd0;
  localparam cp_oper_t EXE_CP_MFC0  = 2'd1;
  localparam cp_oper_t EXE_CP_MTC0  = 2'd2;
  localparam cp_oper_t EXE_CP0_ERET = 2'd3;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int unsigned STATUS_IE      = 0;
  localparam int unsigned STATUS_EXL     = 1;
  localparam int unsigned STATUS_IM_LSB  = 8;
  localparam int unsigned CAUSE_IP_LSB   = 8;
  localparam int unsigned CAUSE_CODE_LSB = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StTake = 2'd1,
    StIsr  = 2'd2,
    StRet  = 2'd3
  } irq_state_e;

endpackage

// File: rtl/interrupt_ctrl_if.sv
// Pipeline-facing CP0 bus: ID-stage context, MFC0/MTC0 access and the PC redirect/flush.
interface interrupt_ctrl_if;
  import interrupt_ctrl_pkg::*;

  logic        id_valid;
  logic        stall;
  logic [31:0] pc_id;
  cp_oper_t    cp_oper;
  logic [4:0]  cp_addr;
  logic [31:0] cp_wdata;
  logic [31:0] cp_rdata;
  logic        ir_flush;
  logic        ir_pc_valid;
  logic [31:0] ir_pc;

  modport master (
    output id_valid, stall, pc_id, cp_oper, cp_addr, cp_wdata,
    input  cp_rdata, ir_flush, ir_pc_valid, ir_pc
  );

  modport slave (
    input  id_valid, stall, pc_id, cp_oper, cp_addr, cp_wdata,
    output cp_rdata, ir_flush, ir_pc_valid, ir_pc
  );
endinterface

// File: rtl/interrupt_ctrl_irq_arbiter.sv
// Synchronises the external request lines and picks the lowest-numbered unmasked pending one.
module interrupt_ctrl_irq_arbiter
  import interrupt_ctrl_pkg::*;
#(
  parameter int unsigned IRQ_NUM     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IRQ_NUM-1:0] ir_in,
  input  logic [IRQ_NUM-1:0] im,
  output logic [IRQ_NUM-1:0] ip,
  output logic               pend_any,
  output irq_idx_t           winner,
  output logic [IRQ_NUM-1:0] grant
);

  logic [IRQ_NUM-1:0] sync_q [SYNC_STAGES];
  logic [IRQ_NUM-1:0] pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= ir_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign ip       = sync_q[SYNC_STAGES-1];
  assign pend     = ip & im;
  assign pend_any = |pend;

  // Scan from the top down so the lowest set index is the one left standing.
  always_comb begin
    winner = '0;
    grant  = '0;
    for (int i = int'(IRQ_NUM) - 1; i >= 0; i--) begin
      if (pend[i]) begin
        winner   = irq_idx_t'(i);
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// CP0 interrupt sequencer: Status/Cause/EPC, take/return FSM, registered redirect and ack.
module interrupt_ctrl
  import interrupt_ctrl_pkg::*;
#(
  parameter int unsigned IRQ_NUM      = 4,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0020,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IRQ_NUM-1:0] ir_in,
  input  logic               ir_en,
  output logic [IRQ_NUM-1:0] ir_ack,
  output logic               ir_busy,
  interrupt_ctrl_if.slave    cp
);

  irq_state_e         state_q, state_d;
  logic               ie_q, ie_d, exl_q, exl_d;
  logic [IRQ_NUM-1:0] im_q, im_d;
  logic [4:0]         code_q, code_d;
  logic [31:0]        epc_q, epc_d;
  logic               flush_q, flush_d, pc_valid_q, pc_valid_d;
  logic [31:0]        pc_q, pc_d;
  logic [IRQ_NUM-1:0] ack_q, ack_d;

  logic [IRQ_NUM-1:0] ip, grant;
  logic               pend_any, take, eret, mtc0;
  irq_idx_t           winner;
  logic [31:0]        rdata;

  interrupt_ctrl_irq_arbiter #(
    .IRQ_NUM     (IRQ_NUM),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_arbiter (
    .clk      (clk),
    .rst      (rst),
    .ir_in    (ir_in),
    .im       (im_q),
    .ip       (ip),
    .pend_any (pend_any),
    .winner   (winner),
    .grant    (grant)
  );

  assign take = (state_q == StIdle) & ie_q & ~exl_q & ir_en & pend_any & cp.id_valid &
                ~cp.stall & (cp.cp_oper != EXE_CP0_ERET);
  assign eret = (state_q == StIsr) & (cp.cp_oper == EXE_CP0_ERET) & cp.id_valid & ~cp.stall;
  // A same-cycle take flushes the MTC0, so its write must not land.
  assign mtc0 = (cp.cp_oper == EXE_CP_MTC0) & cp.id_valid & ~cp.stall & ~take &
                (state_q inside {StIdle, StIsr});

  always_comb begin
    state_d    = state_q;
    ie_d       = ie_q;
    exl_d      = exl_q;
    im_d       = im_q;
    code_d     = code_q;
    epc_d      = epc_q;
    flush_d    = 1'b0;
    pc_valid_d = 1'b0;
    pc_d       = '0;
    ack_d      = '0;

    unique case (state_q)
      StIdle: begin
        if (take) begin
          state_d    = StTake;
          epc_d      = cp.pc_id;
          code_d     = {2'b00, winner};
          exl_d      = 1'b1;
          flush_d    = 1'b1;
          pc_valid_d = 1'b1;
          pc_d       = HANDLER_ADDR;
          ack_d      = grant;
        end
      end
      StTake: state_d = StIsr;
      StIsr: begin
        if (eret) begin
          state_d    = StRet;
          exl_d      = 1'b0;
          flush_d    = 1'b1;
          pc_valid_d = 1'b1;
          pc_d       = epc_q;
        end
      end
      StRet: state_d = StIdle;
    endcase

    if (mtc0) begin
      case (cp.cp_addr)
        CP0_STATUS: begin
          ie_d  = cp.cp_wdata[STATUS_IE];
          exl_d = cp.cp_wdata[STATUS_EXL];
          im_d  = cp.cp_wdata[STATUS_IM_LSB +: IRQ_NUM];
        end
        CP0_EPC: epc_d = cp.cp_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      im_q       <= '0;
      code_q     <= '0;
      epc_q      <= '0;
      flush_q    <= 1'b0;
      pc_valid_q <= 1'b0;
      pc_q       <= '0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      im_q       <= im_d;
      code_q     <= code_d;
      epc_q      <= epc_d;
      flush_q    <= flush_d;
      pc_valid_q <= pc_valid_d;
      pc_q       <= pc_d;
      ack_q      <= ack_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (cp.cp_addr)
      CP0_STATUS: begin
        rdata[STATUS_IE]                  = ie_q;
        rdata[STATUS_EXL]                 = exl_q;
        rdata[STATUS_IM_LSB +: IRQ_NUM]   = im_q;
      end
      CP0_CAUSE: begin
        rdata[CAUSE_IP_LSB +: IRQ_NUM]    = ip;
        rdata[CAUSE_CODE_LSB +: 5]        = code_q;
      end
      CP0_EPC: rdata = epc_q;
      default: ;
    endcase
  end

  assign cp.cp_rdata    = rdata;
  assign cp.ir_flush    = flush_q;
  assign cp.ir_pc_valid = pc_valid_q;
  assign cp.ir_pc       = pc_q;
  assign ir_ack         = ack_q;
  assign ir_busy        = exl_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed scenarios plus a randomized run against an event-level CP0 model.
module tb_interrupt_ctrl;

  localparam int unsigned NIRQ  = 4;
  localparam int unsigned SS    = 2;
  localparam logic [31:0] HADDR = 32'h0000_0020;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NIRQ-1:0] ir_in = '0;
  logic            ir_en = 1'b0;
  logic [NIRQ-1:0] ir_ack;
  logic            ir_busy;

  interrupt_ctrl_if cp ();

  interrupt_ctrl #(
    .IRQ_NUM      (NIRQ),
    .HANDLER_ADDR (HADDR),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ir_in   (ir_in),
    .ir_en   (ir_en),
    .ir_ack  (ir_ack),
    .ir_busy (ir_busy),
    .cp      (cp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cp.id_valid = 1'b1;
    cp.stall    = 1'b0;
    cp.pc_id    = 32'h0;
    cp.cp_oper  = 2'd0;
    cp.cp_addr  = 5'd0;
    cp.cp_wdata = 32'h0;
  endtask

  task automatic do_reset();
    bus_idle();
    ir_in = '0;
    ir_en = 1'b0;
    rst   = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    cp.cp_oper  = 2'd2;
    cp.cp_addr  = addr;
    cp.cp_wdata = data;
    cp.id_valid = 1'b1;
    cp.stall    = 1'b0;
    step();
    cp.cp_oper  = 2'd0;
  endtask

  task automatic mfc0(input logic [4:0] addr, output logic [31:0] data);
    cp.cp_oper = 2'd1;
    cp.cp_addr = addr;
    #1;
    data = cp.cp_rdata;
    cp.cp_oper = 2'd0;
  endtask

  // Steps until a redirect shows up; cycles = -1 when the budget runs out.
  task automatic wait_redirect(input int budget, output int cycles);
    cycles = -1;
    for (int n = 1; n <= budget; n++) begin
      step();
      if (cp.ir_pc_valid === 1'b1) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic leave_handler();
    ir_in = '0;
    repeat (3) step();
    cp.cp_oper  = 2'd3;
    cp.id_valid = 1'b1;
    cp.stall    = 1'b0;
    step();
    cp.cp_oper = 2'd0;
    step();
    total++;
    if (ir_busy !== 1'b0) begin
      bad++; $display("FAIL leave_busy: got %b want 0", ir_busy);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    total++;
    if ({cp.ir_flush, cp.ir_pc_valid, ir_busy} !== 3'b000) begin
      bad++; $display("FAIL reset_ctl: got %b want 000", {cp.ir_flush, cp.ir_pc_valid, ir_busy});
    end
    total++;
    if (cp.ir_pc !== 32'h0 || ir_ack !== '0) begin
      bad++; $display("FAIL reset_pc_ack: got pc=%h ack=%b want 0/0", cp.ir_pc, ir_ack);
    end
    for (int a = 12; a <= 14; a++) begin
      mfc0(5'(a), d);
      total++;
      if (d !== 32'h0) begin
        bad++; $display("FAIL reset_cp0_%0d: got %h want 0", a, d);
      end
    end
  endtask

  task automatic test_basic_take();
    int c;
    logic [31:0] d;
    do_reset();
    ir_in = 4'b0100;
    cp.pc_id = 32'h40;
    ir_en = 1'b1;
    mtc0(5'd12, 32'h0000_0F01);
    wait_redirect(8, c);
    total++;
    if (c !== 2) begin
      bad++; $display("FAIL take_latency: got %0d want 2 cycles after MTC0", c);
    end
    total++;
    if ({cp.ir_flush, cp.ir_pc, ir_ack, ir_busy} !== {1'b1, 32'h20, 4'b0100, 1'b1}) begin
      bad++; $display("FAIL take_outputs: got flush=%b pc=%h ack=%b busy=%b want 1/20/0100/1",
                      cp.ir_flush, cp.ir_pc, ir_ack, ir_busy);
    end
    ir_in = '0;
    step();
    total++;
    if ({cp.ir_pc_valid, cp.ir_flush, ir_ack, ir_busy} !== {1'b0, 1'b0, 4'b0000, 1'b1}) begin
      bad++; $display("FAIL take_one_cycle: got pcv=%b flush=%b ack=%b busy=%b want 0/0/0000/1",
                      cp.ir_pc_valid, cp.ir_flush, ir_ack, ir_busy);
    end
    mfc0(5'd14, d);
    total++;
    if (d !== 32'h40) begin
      bad++; $display("FAIL take_epc: got %h want 00000040", d);
    end
    mfc0(5'd13, d);
    total++;
    if (((d >> 2) & 32'h1f) !== 32'd2) begin
      bad++; $display("FAIL take_code: got %0d want 2", (d >> 2) & 32'h1f);
    end
  endtask

  // Continues from test_basic_take: handler active with EPC=0x40.
  task automatic test_eret();
    int early;
    repeat (3) step();
    cp.cp_oper = 2'd3;
    cp.id_valid = 1'b1;
    cp.stall = 1'b1;
    early = 0;
    repeat (2) begin
      step();
      if (cp.ir_pc_valid === 1'b1) early++;
    end
    total++;
    if (early !== 0 || ir_busy !== 1'b1) begin
      bad++; $display("FAIL eret_stall: got redirects=%0d busy=%b want 0/1", early, ir_busy);
    end
    cp.stall = 1'b0;
    step();
    cp.cp_oper = 2'd0;
    total++;
    if ({cp.ir_pc_valid, cp.ir_flush, cp.ir_pc, ir_busy} !== {1'b1, 1'b1, 32'h40, 1'b0}) begin
      bad++; $display("FAIL eret_return: got pcv=%b flush=%b pc=%h busy=%b want 1/1/40/0",
                      cp.ir_pc_valid, cp.ir_flush, cp.ir_pc, ir_busy);
    end
    step();
    total++;
    if (cp.ir_pc_valid !== 1'b0) begin
      bad++; $display("FAIL eret_one_cycle: got pcv=%b want 0", cp.ir_pc_valid);
    end
    cp.cp_oper = 2'd3;
    early = 0;
    repeat (3) begin
      step();
      if (cp.ir_pc_valid === 1'b1) early++;
    end
    cp.cp_oper = 2'd0;
    total++;
    if (early !== 0) begin
      bad++; $display("FAIL eret_idle: got %0d redirects want 0", early);
    end
  endtask

  task automatic test_priority();
    int c, hits;
    logic [31:0] d;
    do_reset();
    mtc0(5'd12, 32'h0000_0E01);
    ir_in = 4'b1011;
    ir_en = 1'b1;
    wait_redirect(8, c);
    total++;
    if (c < 0 || ir_ack !== 4'b0010) begin
      bad++; $display("FAIL prio_ack: got cycles=%0d ack=%b want >=0/0010", c, ir_ack);
    end
    mfc0(5'd13, d);
    total++;
    if (((d >> 2) & 32'h1f) !== 32'd1) begin
      bad++; $display("FAIL prio_code: got %0d want 1", (d >> 2) & 32'h1f);
    end
    leave_handler();
    ir_in = 4'b0001;
    hits = 0;
    repeat (10) begin
      step();
      if (cp.ir_pc_valid === 1'b1 || ir_ack[0] === 1'b1) hits++;
    end
    total++;
    if (hits !== 0) begin
      bad++; $display("FAIL prio_masked: got %0d takes of line 0 want 0", hits);
    end
    mfc0(5'd13, d);
    total++;
    if (((d >> 8) & 32'hf) !== 32'h1) begin
      bad++; $display("FAIL prio_ip: got %h want 1", (d >> 8) & 32'hf);
    end
  endtask

  task automatic test_stall_gating();
    int early;
    do_reset();
    mtc0(5'd12, 32'h0000_0F01);
    ir_in = 4'b0001;
    repeat (3) step();
    early = 0;
    cp.stall = 1'b1;
    ir_en = 1'b1;
    repeat (3) begin
      step();
      if (cp.ir_pc_valid === 1'b1) early++;
    end
    cp.stall = 1'b0;
    ir_en = 1'b0;
    repeat (2) begin
      step();
      if (cp.ir_pc_valid === 1'b1) early++;
    end
    total++;
    if (early !== 0) begin
      bad++; $display("FAIL gate_blocked: got %0d redirects want 0", early);
    end
    ir_en = 1'b1;
    step();
    total++;
    if (cp.ir_pc_valid !== 1'b1 || ir_ack !== 4'b0001) begin
      bad++; $display("FAIL gate_release: got pcv=%b ack=%b want 1/0001", cp.ir_pc_valid, ir_ack);
    end
    leave_handler();
  endtask

  task automatic test_mtc0_collision();
    logic [31:0] d;
    do_reset();
    mtc0(5'd12, 32'h0000_0F01);
    ir_in = 4'b0010;
    repeat (3) step();
    ir_en = 1'b1;
    cp.cp_oper = 2'd2;
    cp.cp_addr = 5'd12;
    cp.cp_wdata = 32'h0;
    step();
    cp.cp_oper = 2'd0;
    total++;
    if (cp.ir_pc_valid !== 1'b1 || ir_ack !== 4'b0010) begin
      bad++; $display("FAIL coll_take: got pcv=%b ack=%b want 1/0010", cp.ir_pc_valid, ir_ack);
    end
    mfc0(5'd12, d);
    total++;
    if (d !== 32'h0000_0F03) begin
      bad++; $display("FAIL coll_status: got %h want 00000f03", d);
    end
    leave_handler();
    mfc0(5'd12, d);
    total++;
    if (d !== 32'h0000_0F01) begin
      bad++; $display("FAIL coll_status_after: got %h want 00000f01", d);
    end
  endtask

  task automatic test_reset_mid_isr();
    int c, hits;
    logic [31:0] d;
    do_reset();
    mtc0(5'd12, 32'h0000_0F01);
    ir_in = 4'b0001;
    ir_en = 1'b1;
    wait_redirect(8, c);
    step();
    total++;
    if (c < 0 || ir_busy !== 1'b1) begin
      bad++; $display("FAIL rst_isr_setup: got cycles=%0d busy=%b want >=0/1", c, ir_busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if (ir_busy !== 1'b0 || cp.ir_pc_valid !== 1'b0) begin
      bad++; $display("FAIL rst_async: got busy=%b pcv=%b want 0/0", ir_busy, cp.ir_pc_valid);
    end
    step();
    rst = 1'b0;
    hits = 0;
    repeat (12) begin
      step();
      if (cp.ir_pc_valid === 1'b1 || ir_ack !== '0) hits++;
    end
    total++;
    if (hits !== 0) begin
      bad++; $display("FAIL rst_no_take: got %0d takes want 0", hits);
    end
    mfc0(5'd12, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL rst_status: got %h want 0", d);
    end
    mfc0(5'd13, d);
    total++;
    if (d !== 32'h0000_0100) begin
      bad++; $display("FAIL rst_cause: got %h want 00000100", d);
    end
  endtask

  // Model tracks architectural registers plus two facts: is a handler live, and is a
  // redirect being emitted this cycle (which blocks takes, ERETs and MTC0s).
  task automatic test_random();
    bit              m_ie, m_exl, m_handler, m_redir;
    logic [NIRQ-1:0] m_im, ip, pend, e_ack;
    logic [4:0]      m_code;
    logic [31:0]     m_epc, e_rdata, e_pc;
    logic [NIRQ-1:0] hist[$];
    bit              take, eret, wr, e_redir;
    int              w, r;

    do_reset();
    m_ie = 0; m_exl = 0; m_handler = 0; m_redir = 0;
    m_im = '0; m_code = '0; m_epc = '0;
    hist.delete();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 7) == 0) ir_in = NIRQ'($urandom);
      ir_en       = ($urandom_range(0, 3) != 0);
      cp.stall    = ($urandom_range(0, 4) == 0);
      cp.id_valid = ($urandom_range(0, 5) != 0);
      cp.pc_id    = $urandom & 32'hffff_fffc;
      r = $urandom_range(0, 9);
      cp.cp_oper  = (r < 5) ? 2'd0 : (r == 5) ? 2'd1 : (r < 8) ? 2'd2 : 2'd3;
      r = $urandom_range(0, 3);
      cp.cp_addr  = (r == 3) ? 5'($urandom) : 5'(12 + r);
      cp.cp_wdata = $urandom;
      if (cp.cp_addr == 5'd12) begin
        cp.cp_wdata[0] = ($urandom_range(0, 3) != 0);
        cp.cp_wdata[1] = ($urandom_range(0, 7) == 0);
      end
      #1;

      ip = (hist.size() >= SS) ? hist[hist.size() - SS] : '0;
      e_rdata = 32'h0;
      if (cp.cp_addr == 5'd12) e_rdata = 32'(m_ie) | (32'(m_exl) << 1) | (32'(m_im) << 8);
      else if (cp.cp_addr == 5'd13) e_rdata = (32'(ip) << 8) | (32'(m_code) << 2);
      else if (cp.cp_addr == 5'd14) e_rdata = m_epc;
      total++;
      if (cp.cp_rdata !== e_rdata) begin
        bad++; $display("FAIL rnd_rdata[%0d]: addr=%0d got %h want %h",
                        cyc, cp.cp_addr, cp.cp_rdata, e_rdata);
      end

      pend = ip & m_im;
      w = -1;
      for (int i = 0; i < int'(NIRQ); i++) if (pend[i] && w < 0) w = i;
      take = !m_handler && !m_redir && m_ie && !m_exl && ir_en && (w >= 0) &&
             cp.id_valid && !cp.stall && (cp.cp_oper != 2'd3);
      eret = m_handler && !m_redir && (cp.cp_oper == 2'd3) && cp.id_valid && !cp.stall;
      wr   = (cp.cp_oper == 2'd2) && cp.id_valid && !cp.stall && !take && !m_redir;

      e_redir = take || eret;
      e_pc    = take ? HADDR : eret ? m_epc : 32'h0;
      e_ack   = take ? NIRQ'(1 << w) : '0;
      if (take) begin
        m_epc = cp.pc_id; m_code = 5'(w); m_exl = 1; m_handler = 1;
      end
      if (eret) begin
        m_exl = 0; m_handler = 0;
      end
      if (wr && cp.cp_addr == 5'd12) begin
        m_ie = cp.cp_wdata[0]; m_exl = cp.cp_wdata[1]; m_im = cp.cp_wdata[8 +: NIRQ];
      end
      if (wr && cp.cp_addr == 5'd14) m_epc = cp.cp_wdata;
      m_redir = e_redir;
      hist.push_back(ir_in);
      if (hist.size() > SS) void'(hist.pop_front());

      step();
      total++;
      if ({cp.ir_flush, cp.ir_pc_valid, cp.ir_pc, ir_ack, ir_busy} !==
          {e_redir, e_redir, e_pc, e_ack, m_exl}) begin
        bad++; $display("FAIL rnd_out[%0d]: got flush=%b pcv=%b pc=%h ack=%b busy=%b want %b/%b/%h/%b/%b",
                        cyc, cp.ir_flush, cp.ir_pc_valid, cp.ir_pc, ir_ack, ir_busy,
                        e_redir, e_redir, e_pc, e_ack, m_exl);
      end
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_basic_take();
    test_eret();
    test_priority();
    test_stall_gating();
    test_mtc0_collision();
    test_reset_mid_isr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
